// File: rtl/alu_ctrl_stage_pkg.sv
// Shared ALU control definitions: ALU op codes, ALUOp encodings, supported
// R-type funct codes and the buffered entry type used by alu_ctrl_stage.
// Intended to be imported by both this stage and the ALU itself.
package alu_ctrl_stage_pkg;

  // ALU operation codes (ALU ctrl_i port encoding)
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctrl_e;

  // ALUOp from main control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // Supported R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  // One buffered decoded request
  typedef struct packed {
    logic [3:0] ctrl;
    logic [4:0] rd;
    logic       illegal;
    logic       valid;
  } stage_entry_t;

  // Idle/reset contents: outputs show an ADD with tag 0 when nothing is held
  localparam stage_entry_t ENTRY_RST = '{ctrl: ALU_ADD, rd: 5'd0, illegal: 1'b0, valid: 1'b0};

endpackage

// File: rtl/alu_ctrl_stage_if.sv
// Handshake bundle for alu_ctrl_stage.
// Upstream side : valid_i, ready_o, alu_op_i, funct_i, rd_i
// Downstream side: valid_o, ready_i, ctrl_o, rd_o, illegal_o
// slave  = the stage itself, master = the surrounding logic / bench.
interface alu_ctrl_stage_if;
  logic       valid_i;
  logic       ready_o;
  logic [1:0] alu_op_i;
  logic [5:0] funct_i;
  logic [4:0] rd_i;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] ctrl_o;
  logic [4:0] rd_o;
  logic       illegal_o;

  modport slave (
    input  valid_i, alu_op_i, funct_i, rd_i, ready_i,
    output ready_o, valid_o, ctrl_o, rd_o, illegal_o
  );

  modport master (
    output valid_i, alu_op_i, funct_i, rd_i, ready_i,
    input  ready_o, valid_o, ctrl_o, rd_o, illegal_o
  );
endinterface

// File: rtl/alu_ctrl_stage_dec.sv
// alu_ctrl_dec: combinational ALU control decode.
// Ports: i_alu_op (ALUOp), i_funct (instruction funct) ->
//        o_ctrl (ALU op code), o_illegal (unsupported R-type funct).
module alu_ctrl_dec
  import alu_ctrl_stage_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = ALU_ADD;
    o_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_ctrl = ALU_ADD;
      ALUOP_SUB: o_ctrl = ALU_SUB;
      ALUOP_SLT: o_ctrl = ALU_SLT;
      default: begin
        case (i_funct)
          FUNCT_ADD: o_ctrl = ALU_ADD;
          FUNCT_SUB: o_ctrl = ALU_SUB;
          FUNCT_AND: o_ctrl = ALU_AND;
          FUNCT_OR:  o_ctrl = ALU_OR;
          FUNCT_SLT: o_ctrl = ALU_SLT;
          FUNCT_NOR: o_ctrl = ALU_NOR;
          // Unknown funct still issues as ADD so the ALU sees a benign op
          default:   o_illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: decodes ALUOp/funct into an ALU op code and buffers it in a
// two-entry skid buffer (main M drives outputs, skid S catches the request
// accepted in the cycle downstream stalls).
// Ports: clk_i  - clock
//        rst_i  - synchronous active-low reset
//        bus    - alu_ctrl_stage_if.slave handshake bundle
module alu_ctrl_stage
  import alu_ctrl_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  alu_ctrl_stage_if.slave   bus
);

  stage_entry_t r_m, r_s;
  stage_entry_t w_new;
  logic [3:0]   w_ctrl;
  logic         w_illegal;
  logic         w_accept;

  alu_ctrl_dec u_dec (
    .i_alu_op  (bus.alu_op_i),
    .i_funct   (bus.funct_i),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // ready_o depends only on a register, so it never combinationally
  // follows ready_i.
  assign bus.ready_o   = ~r_s.valid;
  assign bus.valid_o   = r_m.valid;
  assign bus.ctrl_o    = r_m.ctrl;
  assign bus.rd_o      = r_m.rd;
  assign bus.illegal_o = r_m.illegal;

  assign w_accept = bus.valid_i & ~r_s.valid;
  assign w_new    = '{ctrl: w_ctrl, rd: bus.rd_i, illegal: w_illegal, valid: 1'b1};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_m <= ENTRY_RST;
      r_s <= ENTRY_RST;
    end else if (w_accept) begin
      // S is empty whenever we accept, so the new entry goes to M if M is
      // free or leaving this edge, otherwise it parks in S.
      if (!r_m.valid || bus.ready_i) r_m <= w_new;
      else                           r_s <= w_new;
    end else if (r_s.valid && bus.ready_i) begin
      r_m       <= r_s;
      r_s.valid <= 1'b0;
    end else if (r_m.valid && bus.ready_i) begin
      r_m.valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  synchronous, active-low reset, sampled on rising edge of clk_i.
REQ-003 valid_i  input  1  upstream decode request valid.
REQ-004 ready_o  output  1  stage can accept a request this cycle.
REQ-005 alu_op_i  input  2  ALUOp from main control.
REQ-006 funct_i  input  6  instruction funct field.
REQ-007 rd_i  input  5  destination register tag, carried unchanged.
REQ-008 valid_o  output  1  ctrl_o/rd_o/illegal_o hold a valid decoded request.
REQ-009 ready_i  input  1  downstream (ALU issue) accepts the presented request.
REQ-010 ctrl_o  output  4  ALU operation code driven to the ALU ctrl_i port.
REQ-011 rd_o  output  5  destination tag of the presented request.
REQ-012 illegal_o  output  1  R-type funct not supported by the ALU.

Function
REQ-013 Decode SHALL be: alu_op 00 -> 0010 (add); 01 -> 0110 (sub); 11 -> 0111 (slt); 10 -> by funct.
REQ-014 R-type funct SHALL map: 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100.
REQ-015 Any other funct with alu_op 10 SHALL give ctrl 0010 and illegal_o=1; illegal_o=0 in all other cases.
REQ-016 Storage SHALL be a main register M (drives outputs) and a skid register S, each holding {ctrl, rd, illegal, valid}.
REQ-017 ready_o SHALL equal ~S.valid (registered, no combinational path from ready_i).
REQ-018 Accept SHALL occur when valid_i & ready_o; decode happens on the input side before storage.
REQ-019 Accept with (~M.valid | ready_i): M <= new request.
REQ-020 Accept with M.valid & ~ready_i: S <= new request, M holds.
REQ-021 No accept, S.valid & ready_i: M <= S, S.valid <= 0.
REQ-022 No accept, M.valid & ready_i & ~S.valid: M.valid <= 0.
REQ-023 Latency SHALL be 1 cycle accept->valid_o; sustained throughput 1 request/cycle when ready_i=1.
REQ-024 While valid_o=1 & ready_i=0, ctrl_o/rd_o/illegal_o SHALL remain stable.
REQ-025 Requests SHALL leave in acceptance order; none dropped or duplicated.
REQ-026 valid_i with ready_o=0 SHALL be ignored; upstream holds.

Reset
REQ-027 While rst_i=0: M.valid=S.valid=0, valid_o=0, ready_o=1 after the edge, ctrl_o=0010, rd_o=0, illegal_o=0.
REQ-028 Reset mid-transfer SHALL discard M and S contents; first request after release is accepted normally.

Structure
REQ-029 ALU op codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100), ALUOp values and supported funct codes SHALL live in a shared package used by this block and the ALU.
REQ-030 Decode SHALL be a combinational sub-module alu_ctrl_dec (alu_op, funct -> ctrl, illegal); buffering stays in alu_ctrl_stage.

Verification
REQ-031 Reset: rst_i=0 two cycles -> valid_o=0, ready_o=1, ctrl_o=0010, rd_o=0.
REQ-032 Decode sweep, ready_i=1: alu_op 10, funct 100111, rd 7 -> next cycle ctrl_o=1100, rd_o=7, illegal_o=0; funct 000000 -> ctrl_o=0010, illegal_o=1.
REQ-033 Back-pressure: stream A(add),B(sub),C(and) with ready_i=0 from cycle 1 -> M=A, S=B, ready_o=0, C held upstream; ready_i=1 -> outputs A,B,C in order, ready_o returns 1.
REQ-034 Full throughput: 8 back-to-back requests, ready_i=1 -> 8 consecutive valid_o cycles, 1-cycle latency, order preserved.
REQ-035 Reset with M and S full -> next cycle valid_o=0, ready_o=1; new request alu_op 01 -> ctrl_o=0110 one cycle later.
REQ-036 Simultaneous accept and drain (M valid, ready_i=1, valid_i=1) -> M replaced same edge, S stays empty, no bubble.
